// File: rtl/ball_move.sv
// rtl/ball_move.sv - motion state of one billiard ball, integrated once per video frame
//
// Purpose:
//   Holds the fixed-point position and velocity of a single ball. On every
//   startOfFrame the ball is advanced by one frame. The frame update first
//   checks for a pocket (the ball sinks), then adds the velocity to the
//   position, then takes over the other ball's velocity on a ball-to-ball
//   hit, then bounces off the cushions, and finally applies friction.
//
// Ports:
//   clk, resetN                  clock, asynchronous active-low reset
//   startOfFrame                 one-cycle pulse that triggers the frame update
//   hitStart, launchSpeedX/Y     cue launch (only honoured while idle)
//   collisionWithBall,
//   otherSpeedX/Y                ball-to-ball hit and the other ball's velocity
//   collisionHole                ball overlaps a pocket
//   respawn                      put a sunk ball back on the table
//   ballTopLeftPosX/Y            integer pixel position for the renderer
//   ballSpeedX/Y                 signed current velocity, 1/64 px per frame
//   ballShow, ballMoving         visibility and motion status
module ball_move #(
    parameter int INITIAL_X = 280,
    parameter int INITIAL_Y = 200,
    parameter int FRAC_BITS = 6,
    parameter int FRICTION  = 1,
    parameter int MAX_SPEED = 960,
    parameter int MIN_X     = 40,
    parameter int MAX_X     = 600,
    parameter int MIN_Y     = 40,
    parameter int MAX_Y     = 440,
    parameter int BALL_SIZE = 32
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        hitStart,
    input  logic [10:0] launchSpeedX,
    input  logic [10:0] launchSpeedY,
    input  logic        collisionWithBall,
    input  logic [10:0] otherSpeedX,
    input  logic [10:0] otherSpeedY,
    input  logic        collisionHole,
    input  logic        respawn,
    output logic [10:0] ballTopLeftPosX,
    output logic [10:0] ballTopLeftPosY,
    output logic [10:0] ballSpeedX,
    output logic [10:0] ballSpeedY,
    output logic        ballShow,
    output logic        ballMoving
);

    localparam int POS_W = 11 + FRAC_BITS;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MOVING = 2'd1;
    localparam logic [1:0] ST_SUNK   = 2'd2;

    // Cushion limits and spawn point in fixed-point units
    localparam logic signed [POS_W-1:0] X_LO   = POS_W'(MIN_X << FRAC_BITS);
    localparam logic signed [POS_W-1:0] X_HI   = POS_W'((MAX_X - BALL_SIZE) << FRAC_BITS);
    localparam logic signed [POS_W-1:0] Y_LO   = POS_W'(MIN_Y << FRAC_BITS);
    localparam logic signed [POS_W-1:0] Y_HI   = POS_W'((MAX_Y - BALL_SIZE) << FRAC_BITS);
    localparam logic signed [POS_W-1:0] X_INIT = POS_W'(INITIAL_X << FRAC_BITS);
    localparam logic signed [POS_W-1:0] Y_INIT = POS_W'(INITIAL_Y << FRAC_BITS);

    localparam logic signed [10:0] V_MAX  = 11'(MAX_SPEED);
    localparam logic signed [10:0] V_FRIC = 11'(FRICTION);
    localparam logic signed [10:0] V_ZERO = 11'sd0;

    function automatic logic signed [10:0] sat_v(input logic signed [10:0] v);
        if (v > V_MAX) begin
            return V_MAX;
        end else if (v < -V_MAX) begin
            return -V_MAX;
        end
        return v;
    endfunction

    // Inputs to this are always within +-MAX_SPEED, so negation cannot overflow
    function automatic logic signed [10:0] abs_v(input logic signed [10:0] v);
        return v[10] ? -v : v;
    endfunction

    function automatic logic signed [10:0] fric_v(input logic signed [10:0] v);
        if (abs_v(v) <= V_FRIC) begin
            return V_ZERO;
        end else if (v[10]) begin
            return v + V_FRIC;
        end
        return v - V_FRIC;
    endfunction

    function automatic logic signed [POS_W-1:0] sext(input logic signed [10:0] v);
        return {{(POS_W-11){v[10]}}, v};
    endfunction

    logic [1:0]               state_q, state_d;
    logic signed [POS_W-1:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic signed [10:0]       vel_x_q, vel_x_d, vel_y_q, vel_y_d;
    logic                     hole_flag_q, hole_flag_d;
    logic                     ball_flag_q, ball_flag_d;
    logic signed [10:0]       other_x_q, other_x_d, other_y_q, other_y_d;
    logic                     show_q, show_d;
    logic                     moving_q, moving_d;

    // Frame-update intermediate results
    logic                     hole_pend, ball_pend;
    logic signed [10:0]       other_x_eff, other_y_eff;
    logic signed [10:0]       launch_x_sat, launch_y_sat;
    logic signed [POS_W-1:0]  step_x, step_y;
    logic signed [10:0]       coll_vx, coll_vy, bnc_vx, bnc_vy;
    logic signed [POS_W-1:0]  pos_x_frm, pos_y_frm;
    logic signed [10:0]       vel_x_frm, vel_y_frm;
    logic                     frame_stop, launch_zero;

    always_comb begin : frame_calc
        // A collision pulse landing on the startOfFrame cycle counts for this frame
        hole_pend    = hole_flag_q | collisionHole;
        ball_pend    = ball_flag_q | collisionWithBall;
        other_x_eff  = collisionWithBall ? $signed(otherSpeedX) : other_x_q;
        other_y_eff  = collisionWithBall ? $signed(otherSpeedY) : other_y_q;
        launch_x_sat = sat_v($signed(launchSpeedX));
        launch_y_sat = sat_v($signed(launchSpeedY));
        launch_zero  = (launch_x_sat == V_ZERO) && (launch_y_sat == V_ZERO);

        // Integrate with the velocity held at the start of the frame
        step_x = pos_x_q + sext(vel_x_q);
        step_y = pos_y_q + sext(vel_y_q);

        coll_vx = ball_pend ? sat_v(other_x_eff) : vel_x_q;
        coll_vy = ball_pend ? sat_v(other_y_eff) : vel_y_q;

        // Force the sign towards the table rather than toggling it, so a ball
        // resting on a cushion is never pushed back into it
        pos_x_frm = step_x;
        bnc_vx    = coll_vx;
        if (step_x < X_LO) begin
            pos_x_frm = X_LO;
            bnc_vx    = abs_v(coll_vx);
        end else if (step_x > X_HI) begin
            pos_x_frm = X_HI;
            bnc_vx    = -abs_v(coll_vx);
        end

        pos_y_frm = step_y;
        bnc_vy    = coll_vy;
        if (step_y < Y_LO) begin
            pos_y_frm = Y_LO;
            bnc_vy    = abs_v(coll_vy);
        end else if (step_y > Y_HI) begin
            pos_y_frm = Y_HI;
            bnc_vy    = -abs_v(coll_vy);
        end

        vel_x_frm  = fric_v(bnc_vx);
        vel_y_frm  = fric_v(bnc_vy);
        frame_stop = (vel_x_frm == V_ZERO) && (vel_y_frm == V_ZERO);
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (startOfFrame) begin
                    if (hole_pend) begin
                        state_d = ST_SUNK;
                    end else if (!frame_stop) begin
                        state_d = ST_MOVING;
                    end
                end else if (hitStart && !launch_zero) begin
                    state_d = ST_MOVING;
                end
            end
            ST_MOVING: begin
                if (startOfFrame) begin
                    if (hole_pend) begin
                        state_d = ST_SUNK;
                    end else if (frame_stop) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_SUNK: begin
                if (respawn) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin : datapath_next
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        vel_x_d     = vel_x_q;
        vel_y_d     = vel_y_q;
        hole_flag_d = hole_flag_q;
        ball_flag_d = ball_flag_q;
        other_x_d   = other_x_q;
        other_y_d   = other_y_q;
        case (state_q)
            ST_IDLE, ST_MOVING: begin
                if (collisionHole) begin
                    hole_flag_d = 1'b1;
                end
                if (collisionWithBall) begin
                    ball_flag_d = 1'b1;
                    other_x_d   = $signed(otherSpeedX);
                    other_y_d   = $signed(otherSpeedY);
                end
                if (startOfFrame) begin
                    hole_flag_d = 1'b0;
                    ball_flag_d = 1'b0;
                    if (hole_pend) begin
                        vel_x_d = V_ZERO;
                        vel_y_d = V_ZERO;
                    end else begin
                        pos_x_d = pos_x_frm;
                        pos_y_d = pos_y_frm;
                        vel_x_d = vel_x_frm;
                        vel_y_d = vel_y_frm;
                    end
                end else if ((state_q == ST_IDLE) && hitStart) begin
                    vel_x_d = launch_x_sat;
                    vel_y_d = launch_y_sat;
                end
            end
            ST_SUNK: begin
                vel_x_d     = V_ZERO;
                vel_y_d     = V_ZERO;
                hole_flag_d = 1'b0;
                ball_flag_d = 1'b0;
                if (respawn) begin
                    pos_x_d = X_INIT;
                    pos_y_d = Y_INIT;
                end
            end
            default: begin
                vel_x_d = V_ZERO;
                vel_y_d = V_ZERO;
            end
        endcase
    end

    always_comb begin : output_next
        show_d   = (state_d != ST_SUNK);
        moving_d = (state_d == ST_MOVING);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ST_IDLE;
            pos_x_q     <= X_INIT;
            pos_y_q     <= Y_INIT;
            vel_x_q     <= V_ZERO;
            vel_y_q     <= V_ZERO;
            hole_flag_q <= 1'b0;
            ball_flag_q <= 1'b0;
            other_x_q   <= V_ZERO;
            other_y_q   <= V_ZERO;
            show_q      <= 1'b1;
            moving_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            vel_x_q     <= vel_x_d;
            vel_y_q     <= vel_y_d;
            hole_flag_q <= hole_flag_d;
            ball_flag_q <= ball_flag_d;
            other_x_q   <= other_x_d;
            other_y_q   <= other_y_d;
            show_q      <= show_d;
            moving_q    <= moving_d;
        end
    end

    assign ballTopLeftPosX = pos_x_q[FRAC_BITS +: 11];
    assign ballTopLeftPosY = pos_y_q[FRAC_BITS +: 11];
    assign ballSpeedX      = vel_x_q;
    assign ballSpeedY      = vel_y_q;
    assign ballShow        = show_q;
    assign ballMoving      = moving_q;

endmodule
